lstm_gate_sched: RTL and testbench

Sequencer that time-multiplexes one shared gate datapath (dot-product X/Y plus bias) across the four LSTM gates, input (i), forget (f), candidate (g) and output (o), for every timestep of an input sequence. It accepts per-step input vectors over a ready/valid handshake and starts the gate once per gate type. It captures each gate result into a dedicated register, then starts the element-wise cell/hidden update and tells the hidden-state register to reload. It sits between the layer's input feeder and the gate, element-wise and h-register blocks.

---
 rtl/lstm_gate_sched.sv | 111 +++++++++++
 tb/tb_lstm_gate_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lstm_gate_sched.sv
// lstm_gate_sched: issues the i/f/g/o gates of each timestep on one shared gate datapath, captures each result, then starts the element-wise update and reloads h
module lstm_gate_sched #(
  parameter int HIDDEN_SZ = 16,
  parameter int QN = 6,
  parameter int QM = 11,
  parameter int BITWIDTH = QN + QM + 1,
  parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  parameter int STEP_BITWIDTH = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [STEP_BITWIDTH-1:0]  seqLen,
  input  logic                      xValid,
  output logic                      xReady,
  output logic                      gateStart,
  output logic [1:0]                gateSel,
  input  logic                      gateDone,
  input  logic [LAYER_BITWIDTH-1:0] gateOutput,
  output logic [LAYER_BITWIDTH-1:0] gateVec_i,
  output logic [LAYER_BITWIDTH-1:0] gateVec_f,
  output logic [LAYER_BITWIDTH-1:0] gateVec_g,
  output logic [LAYER_BITWIDTH-1:0] gateVec_o,
  output logic                      ewStart,
  input  logic                      ewDone,
  output logic                      hLoad,
  output logic [STEP_BITWIDTH-1:0]  stepCount,
  output logic                      busy,
  output logic                      done,
  output logic                      timeoutErr
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 2);
  typedef enum logic [2:0] {IDLE, WAIT_X, ISSUE, WAIT_GATE, EW_ISSUE, WAIT_EW, STEP_END, DONE} state_t;
  state_t state;
  logic [1:0] gate_idx;
  logic [STEP_BITWIDTH-1:0] seq_len;
  logic [CW-1:0] wait_cnt;
  logic expired;
  logic [STEP_BITWIDTH-1:0] next_step;
  assign expired = wait_cnt == LIM;
  assign next_step = stepCount + STEP_BITWIDTH'(1);
  assign xReady = state == WAIT_X;
  assign gateStart = state == ISSUE;
  assign ewStart = state == EW_ISSUE;
  assign hLoad = state == STEP_END;
  assign done = state == DONE;
  assign busy = state != IDLE;
  assign gateSel = gate_idx;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      gate_idx <= '0;
      seq_len <= '0;
      wait_cnt <= '0;
      stepCount <= '0;
      timeoutErr <= 1'b0;
      gateVec_i <= '0;
      gateVec_f <= '0;
      gateVec_g <= '0;
      gateVec_o <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          timeoutErr <= 1'b0;
          stepCount <= '0;
          seq_len <= seqLen;
          state <= seqLen == '0 ? DONE : WAIT_X;
        end
        WAIT_X: if (xValid) begin
          gate_idx <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= '0;
          state <= WAIT_GATE;
        end
        WAIT_GATE: if (gateDone) begin
          if (gate_idx == 2'd0) gateVec_i <= gateOutput;
          if (gate_idx == 2'd1) gateVec_f <= gateOutput;
          if (gate_idx == 2'd2) gateVec_g <= gateOutput;
          if (gate_idx == 2'd3) gateVec_o <= gateOutput;
          if (gate_idx == 2'd3) state <= EW_ISSUE;
          else begin
            gate_idx <= gate_idx + 2'd1;
            state <= ISSUE;
          end
        end else if (expired) begin
          timeoutErr <= 1'b1;
          state <= IDLE;
        end else wait_cnt <= wait_cnt + CW'(1);
        EW_ISSUE: begin
          wait_cnt <= '0;
          state <= WAIT_EW;
        end
        WAIT_EW: if (ewDone) state <= STEP_END;
        else if (expired) begin
          timeoutErr <= 1'b1;
          state <= IDLE;
        end else wait_cnt <= wait_cnt + CW'(1);
        STEP_END: begin
          stepCount <= next_step;
          state <= next_step == seq_len ? DONE : WAIT_X;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_gate_sched.sv
// tb_lstm_gate_sched: directed checks of gate sequencing, handshakes, timeout and reset of lstm_gate_sched
module tb_lstm_gate_sched;
  localparam int LW = 18 * 16;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, xValid = 1'b0, gateDone = 1'b0, ewDone = 1'b0;
  logic [7:0] seqLen = '0;
  logic [LW-1:0] gateOutput = '0;
  logic xReady, gateStart, ewStart, hLoad, busy, done, timeoutErr;
  logic [1:0] gateSel;
  logic [7:0] stepCount;
  logic [LW-1:0] gateVec_i, gateVec_f, gateVec_g, gateVec_o;
  int errors = 0, checks = 0;
  int cyc = 0, ngs = 0, nh = 0, ndone = 0, dcyc = 0;
  int sels[16];
  int hl[4];
  logic auto_rsp = 1'b0, gs_last = 1'b0, es_last = 1'b0;
  logic [LW-1:0] base = '0;

  lstm_gate_sched #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .seqLen(seqLen),
    .xValid(xValid), .xReady(xReady), .gateStart(gateStart), .gateSel(gateSel),
    .gateDone(gateDone), .gateOutput(gateOutput),
    .gateVec_i(gateVec_i), .gateVec_f(gateVec_f), .gateVec_g(gateVec_g), .gateVec_o(gateVec_o),
    .ewStart(ewStart), .ewDone(ewDone), .hLoad(hLoad), .stepCount(stepCount),
    .busy(busy), .done(done), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (gateStart) begin
      if (ngs < 16) sels[ngs] = int'(gateSel);
      ngs++;
    end
    if (hLoad) begin
      if (nh < 4) hl[nh] = cyc;
      nh++;
    end
    if (done) begin
      dcyc = cyc;
      ndone++;
    end
    gateDone = auto_rsp && gs_last;
    ewDone = auto_rsp && es_last;
    if (auto_rsp) gateOutput = base + LW'(gateSel);
    gs_last = gateStart;
    es_last = ewStart;
  endtask

  task automatic clr();
    ngs = 0;
    nh = 0;
    ndone = 0;
    dcyc = 0;
  endtask

  task automatic run_to_done(input int bound);
    for (int i = 0; i < bound && ndone == 0; i++) tick();
    chk("done_seen", LW'(ndone), LW'(1));
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_xready", xReady, 0);
    chk("rst_step", stepCount, 0);
    chk("rst_sel", gateSel, 0);
    chk("rst_vec_o", gateVec_o, 0);
    chk("rst_tmo", timeoutErr, 0);
    // seqLen = 0 goes straight to DONE
    clr();
    seqLen = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_xready", xReady, 0);
    tick();
    chk("zero_idle", busy, 0);
    chk("zero_gs", LW'(ngs), 0);
    chk("zero_step", stepCount, 0);
    // two steps with single-cycle gate/ew responses
    clr();
    auto_rsp = 1'b1;
    base = LW'(1);
    xValid = 1'b1;
    seqLen = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("main_wait_x", xReady, 1);
    tick();
    chk("main_issue", gateStart, 1);
    run_to_done(60);
    chk("main_ngs", LW'(ngs), LW'(8));
    for (int i = 0; i < 8; i++) chk($sformatf("main_sel%0d", i), LW'(sels[i]), LW'(i % 4));
    chk("main_nh", LW'(nh), LW'(2));
    chk("main_hgap", LW'(hl[1] - hl[0]), LW'(12));
    chk("main_done_gap", LW'(dcyc - hl[1]), LW'(1));
    chk("main_step", stepCount, 2);
    chk("main_vec_i", gateVec_i, LW'(1));
    chk("main_vec_f", gateVec_f, LW'(2));
    chk("main_vec_o", gateVec_o, LW'(4));
    tick();
    chk("main_idle", busy, 0);
    // xValid withheld with spurious done inputs in WAIT_X
    clr();
    auto_rsp = 1'b0;
    xValid = 1'b0;
    seqLen = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gateDone = 1'b1;
      ewDone = 1'b1;
      gateOutput = LW'(12'hBAD);
      tick();
      chk($sformatf("hold_xready%0d", i), xReady, 1);
    end
    chk("hold_vec_i", gateVec_i, LW'(1));
    chk("hold_vec_g", gateVec_g, LW'(3));
    chk("hold_ngs", LW'(ngs), 0);
    auto_rsp = 1'b1;
    base = LW'(8'h10);
    xValid = 1'b1;
    tick();
    chk("hold_issue", gateStart, 1);
    chk("hold_sel0", gateSel, 0);
    run_to_done(40);
    chk("hold_vec_g2", gateVec_g, LW'(8'h12));
    chk("hold_step", stepCount, 1);
    tick();
    // gate never answers: abort after 15 cycles in WAIT_GATE
    clr();
    auto_rsp = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("tmo_issue", gateStart, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_busy_last", busy, 1);
    chk("tmo_err_early", timeoutErr, 0);
    tick();
    chk("tmo_idle", busy, 0);
    chk("tmo_err", timeoutErr, 1);
    chk("tmo_no_done", LW'(ndone), 0);
    chk("tmo_vec_i", gateVec_i, LW'(8'h10));
    // restart clears the flag; start held while busy; done on the expiry cycle wins
    clr();
    start = 1'b1;
    tick();
    chk("re_err_clr", timeoutErr, 0);
    tick();
    chk("re_issue", gateStart, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("re_still_wait", busy, 1);
    gateDone = 1'b1;
    gateOutput = LW'(12'h777);
    tick();
    chk("re_capture", gateVec_i, LW'(12'h777));
    chk("re_next_issue", gateStart, 1);
    chk("re_sel1", gateSel, 1);
    chk("re_err", timeoutErr, 0);
    start = 1'b0;
    auto_rsp = 1'b1;
    base = LW'(8'h20);
    run_to_done(40);
    chk("re_step", stepCount, 1);
    chk("re_err_end", timeoutErr, 0);
    chk("re_vec_o", gateVec_o, LW'(8'h23));
    tick();
    // reset in WAIT_EW of the second step
    clr();
    base = LW'(1);
    seqLen = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ewStart && nh == 1) break;
    end
    chk("rst_at_ew", ewStart, 1);
    tick();
    chk("rst_pre_step", stepCount, 1);
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_step", stepCount, 0);
    chk("mid_vec_i", gateVec_i, 0);
    chk("mid_vec_o", gateVec_o, 0);
    tick();
    tick();
    chk("mid_no_hload", LW'(nh), 0);
    chk("mid_no_done", LW'(ndone), 0);
    chk("mid_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
